// File: rtl/div5_quot_merge_pkg.sv
// Shared constants and types for the divide-by-5 merge datapath.
package div5_pkg;

  localparam int unsigned DIVISOR = 5;
  localparam int unsigned REM_W   = 3;
  localparam int unsigned RSUM_W  = 5;
  localparam int unsigned PART_QW = 33;

  typedef struct packed {
    logic [PART_QW-1:0] q;
    logic [REM_W-1:0]   r;
  } div5_part_t;

  // Returns {corr, rem} for a remainder sum of up to 21.
  function automatic logic [5:0] fold5(input logic [RSUM_W-1:0] rsum);
    return {3'(rsum / RSUM_W'(DIVISOR)), 3'(rsum % RSUM_W'(DIVISOR))};
  endfunction

endpackage

// File: rtl/div5_quot_merge_if.sv
// Producer/consumer bundle for the divide-by-5 merge stage.
interface div5_quot_merge_if #(
  parameter int unsigned PQW  = 33,
  parameter int unsigned QW   = 32,
  parameter int unsigned TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [PQW-1:0]  in_q0;
  logic [PQW-1:0]  in_q1;
  logic [PQW-1:0]  in_q2;
  logic [2:0]      in_r0;
  logic [2:0]      in_r1;
  logic [2:0]      in_r2;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   out_quot;
  logic [2:0]      out_rem;
  logic [TAGW-1:0] out_tag;
  logic            out_ovf;
  logic            out_err;

  modport master (
    output in_valid, in_q0, in_q1, in_q2, in_r0, in_r1, in_r2, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_tag, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_q0, in_q1, in_q2, in_r0, in_r1, in_r2, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_tag, out_ovf, out_err
  );
endinterface

// File: rtl/div5_rem_fold.sv
// Folds a remainder sum (0..21) into a quotient correction and final remainder.
module div5_rem_fold
  import div5_pkg::*;
(
  input  logic [RSUM_W-1:0] rsum,
  output logic [2:0]        corr,
  output logic [REM_W-1:0]  rem
);

  always_comb begin
    {corr, rem} = '0;
    case (rsum)
      5'd0:  {corr, rem} = {3'd0, 3'd0};
      5'd1:  {corr, rem} = {3'd0, 3'd1};
      5'd2:  {corr, rem} = {3'd0, 3'd2};
      5'd3:  {corr, rem} = {3'd0, 3'd3};
      5'd4:  {corr, rem} = {3'd0, 3'd4};
      5'd5:  {corr, rem} = {3'd1, 3'd0};
      5'd6:  {corr, rem} = {3'd1, 3'd1};
      5'd7:  {corr, rem} = {3'd1, 3'd2};
      5'd8:  {corr, rem} = {3'd1, 3'd3};
      5'd9:  {corr, rem} = {3'd1, 3'd4};
      5'd10: {corr, rem} = {3'd2, 3'd0};
      5'd11: {corr, rem} = {3'd2, 3'd1};
      5'd12: {corr, rem} = {3'd2, 3'd2};
      5'd13: {corr, rem} = {3'd2, 3'd3};
      5'd14: {corr, rem} = {3'd2, 3'd4};
      5'd15: {corr, rem} = {3'd3, 3'd0};
      5'd16: {corr, rem} = {3'd3, 3'd1};
      5'd17: {corr, rem} = {3'd3, 3'd2};
      5'd18: {corr, rem} = {3'd3, 3'd3};
      5'd19: {corr, rem} = {3'd3, 3'd4};
      5'd20: {corr, rem} = {3'd4, 3'd0};
      5'd21: {corr, rem} = {3'd4, 3'd1};
      default: {corr, rem} = '0;
    endcase
  end

endmodule

// File: rtl/div5_quot_merge.sv
// Final merge of partial quotients/remainders into x/5 and x%5.
// Two register stages: carry-save reduction, then fold + carry-propagate add.
module div5_quot_merge
  import div5_pkg::*;
#(
  parameter int unsigned PQW  = 33,
  parameter int unsigned QW   = 32,
  parameter int unsigned TAGW = 4
) (
  input logic               clk,
  input logic               rst,
  div5_quot_merge_if.slave  bus
);

  localparam int unsigned SW = PQW + 2;

  logic              adv;
  logic [SW-1:0]     qa, qb, qc;
  logic [SW-1:0]     csa_sum, csa_carry;
  logic [RSUM_W-1:0] rsum_in;
  logic              err_in;

  logic              s1_valid;
  logic [SW-1:0]     s1_sum, s1_carry;
  logic [RSUM_W-1:0] s1_rsum;
  logic              s1_err;
  logic [TAGW-1:0]   s1_tag;

  logic [2:0]        corr;
  logic [REM_W-1:0]  rem;
  logic [SW-1:0]     full;

  logic              out_valid;
  logic [QW-1:0]     out_quot;
  logic [REM_W-1:0]  out_rem;
  logic [TAGW-1:0]   out_tag;
  logic              out_ovf;
  logic              out_err;

  assign adv = ~out_valid | bus.out_ready;

  always_comb begin
    qa        = SW'(bus.in_q0);
    qb        = SW'(bus.in_q1);
    qc        = SW'(bus.in_q2);
    csa_sum   = qa ^ qb ^ qc;
    // Majority bit of PQW-wide operands never reaches the top bit, so the shift is lossless.
    csa_carry = ((qa & qb) | (qa & qc) | (qb & qc)) << 1;
    rsum_in   = RSUM_W'(bus.in_r0) + RSUM_W'(bus.in_r1) + RSUM_W'(bus.in_r2);
    err_in    = (bus.in_r0 >= REM_W'(DIVISOR)) | (bus.in_r1 >= REM_W'(DIVISOR)) |
                (bus.in_r2 >= REM_W'(DIVISOR));
  end

  div5_rem_fold u_fold (
    .rsum (s1_rsum),
    .corr (corr),
    .rem  (rem)
  );

  assign full = s1_sum + s1_carry + SW'(corr);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      s1_rsum   <= '0;
      s1_err    <= 1'b0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= bus.in_valid;
      s1_sum    <= csa_sum;
      s1_carry  <= csa_carry;
      s1_rsum   <= rsum_in;
      s1_err    <= err_in;
      s1_tag    <= bus.in_tag;
      out_valid <= s1_valid;
      out_quot  <= full[QW-1:0];
      out_rem   <= rem;
      out_tag   <= s1_tag;
      out_ovf   <= |full[SW-1:QW];
      out_err   <= s1_err;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid;
  assign bus.out_quot  = out_quot;
  assign bus.out_rem   = out_rem;
  assign bus.out_tag   = out_tag;
  assign bus.out_ovf   = out_ovf;
  assign bus.out_err   = out_err;

endmodule

// File: tb/tb_div5_quot_merge.sv
// Bench for div5_quot_merge: directed cases plus randomized dividends against x/5, x%5.
module tb_div5_quot_merge;
  import div5_pkg::*;

  typedef struct {
    logic [31:0] quot;
    logic [2:0]  rem;
    logic [3:0]  tag;
    logic        ovf;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div5_quot_merge_if #(.PQW(33), .QW(32), .TAGW(4)) bus ();
  div5_quot_merge #(.PQW(33), .QW(32), .TAGW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  exp_t        pend;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n_out = 0;
  int unsigned cyc = 0;
  int          bp_mode = 0;
  bit          took = 0;
  bit          stalled_prev = 0;
  logic [41:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [32:0] q0, q1, q2,
                                 input logic [2:0] r0, r1, r2, input logic [3:0] tag);
    exp_t e;
    longint unsigned rs, tot;
    rs    = 64'(r0) + 64'(r1) + 64'(r2);
    tot   = 64'(q0) + 64'(q1) + 64'(q2) + rs / 5;
    e.quot = tot[31:0];
    e.ovf  = (tot >> 32) != 0;
    e.rem  = 3'(rs % 5);
    e.err  = (r0 > 4) || (r1 > 4) || (r2 > 4);
    e.tag  = tag;
    return e;
  endfunction

  task automatic apply(input logic [32:0] q0, q1, q2, input logic [2:0] r0, r1, r2,
                       input logic [3:0] tag, input exp_t e);
    bus.in_q0 = q0; bus.in_q1 = q1; bus.in_q2 = q2;
    bus.in_r0 = r0; bus.in_r1 = r1; bus.in_r2 = r2;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    pend = e;
  endtask

  // Golden partial tables: slices of 11/11/10 bits weighted by 2^0, 2^11, 2^22.
  task automatic drive_div(input logic [31:0] x, input logic [3:0] tag);
    div5_part_t p[3];
    longint unsigned v;
    for (int i = 0; i < 3; i++) begin
      v = (longint'(x) >> (11 * i)) & 64'h7FF;
      v = v << (11 * i);
      p[i].q = 33'(v / 5);
      p[i].r = 3'(v % 5);
    end
    apply(p[0].q, p[1].q, p[2].q, p[0].r, p[1].r, p[2].r, tag,
          '{quot: x / 5, rem: 3'(x % 5), tag: tag, ovf: 1'b0, err: 1'b0});
  endtask

  task automatic cycle();
    exp_t e;
    if (bp_mode == 1) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else if (bp_mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
    cyc++;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (stalled_prev)
        chk("stall_stable", {bus.out_valid, bus.out_quot, bus.out_rem, bus.out_tag,
                             bus.out_ovf, bus.out_err}, snap);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("spurious_out", bus.out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("quot", bus.out_quot, e.quot);
          chk("rem", bus.out_rem, e.rem);
          chk("tag", bus.out_tag, e.tag);
          chk("ovf", bus.out_ovf, e.ovf);
          chk("err", bus.out_err, e.err);
          n_out++;
        end
      end
      took = bus.in_valid && bus.in_ready;
      if (took) sb.push_back(pend);
      stalled_prev = bus.out_valid && !bus.out_ready;
      snap = {bus.out_valid, bus.out_quot, bus.out_rem, bus.out_tag, bus.out_ovf, bus.out_err};
    end else begin
      took = 0;
      stalled_prev = 0;
    end
    @(posedge clk);
    #1;
    if (rst) sb.delete();
  endtask

  task automatic send();
    took = 0;
    for (int i = 0; i < 64 && !took; i++) cycle();
    if (!took) chk("send_timeout", took, 1);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 64 && sb.size() != 0; i++) cycle();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int unsigned n0;
    exp_t e;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    apply(33'd11, 33'd22, 33'd33, 3'd1, 3'd1, 3'd1, 4'd7, model(11, 22, 33, 1, 1, 1, 7));

    // Reset held 3 cycles with a live input.
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_quot", bus.out_quot, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end
    chk("rst_out_misc", {bus.out_rem, bus.out_tag, bus.out_ovf, bus.out_err}, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      cycle();
      chk("post_rst_idle", bus.out_valid, 0);
    end

    // Remainder fold with exact 2-cycle latency.
    apply(100, 200, 300, 4, 4, 4, 5, '{quot: 602, rem: 2, tag: 5, ovf: 0, err: 0});
    cycle();
    chk("fold_took", took, 1);
    bus.in_valid = 1'b0;
    chk("fold_lat1", bus.out_valid, 0);
    cycle();
    chk("fold_lat2", bus.out_valid, 1);
    chk("fold_quot", bus.out_quot, 602);
    chk("fold_rem", bus.out_rem, 2);
    chk("fold_tag", bus.out_tag, 5);
    chk("fold_flags", {bus.out_ovf, bus.out_err}, 0);
    drain();

    // Full-range dividend, overflow and illegal remainders back-to-back.
    drive_div(32'hFFFF_FFFF, 4'd3);
    pend = '{quot: 858993459, rem: 0, tag: 3, ovf: 0, err: 0};
    send();
    apply(33'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, '{quot: 0, rem: 0, tag: 1, ovf: 1, err: 0});
    send();
    apply(0, 0, 0, 7, 7, 7, 2, '{quot: 4, rem: 1, tag: 2, ovf: 0, err: 1});
    send();
    drain();

    // Backpressure: out_ready 1,0,0,1 repeating, 8 items.
    bp_mode = 1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      logic [32:0] q0, q1, q2;
      logic [2:0]  r0, r1, r2;
      q0 = 33'($urandom_range(0, 1 << 30)); q1 = 33'($urandom_range(0, 1 << 30));
      q2 = 33'($urandom_range(0, 1 << 30));
      r0 = 3'($urandom_range(0, 4)); r1 = 3'($urandom_range(0, 4)); r2 = 3'($urandom_range(0, 4));
      apply(q0, q1, q2, r0, r1, r2, 4'(i), model(q0, q1, q2, r0, r1, r2, 4'(i)));
      send();
    end
    drain();
    chk("bp_count", n_out - n0, 8);

    // Random dividend sweep with random backpressure.
    bp_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      drive_div($urandom, 4'(i));
      send();
    end
    drain();
    bp_mode = 0;

    // Mid-stream reset with two items in flight and stalled.
    bus.out_ready = 1'b0;
    apply(5, 6, 7, 0, 1, 2, 4'hA, model(5, 6, 7, 0, 1, 2, 4'hA));
    send();
    apply(8, 9, 10, 3, 3, 3, 4'hB, model(8, 9, 10, 3, 3, 3, 4'hB));
    send();
    bus.in_valid = 1'b0;
    chk("stall_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    cycle();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    e = model(10, 20, 30, 1, 2, 3, 4'h9);
    apply(10, 20, 30, 1, 2, 3, 4'h9, e);
    cycle();
    chk("mid_rst_took", took, 1);
    bus.in_valid = 1'b0;
    chk("mid_rst_lat1", bus.out_valid, 0);
    cycle();
    chk("mid_rst_lat2", bus.out_valid, 1);
    chk("mid_rst_quot", bus.out_quot, 61);
    chk("mid_rst_rem", bus.out_rem, 1);
    chk("mid_rst_tag", bus.out_tag, 9);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
